// File: rtl/bus_arbiter.sv
// bus_arbiter: shares memory_bus between the CPU and a DMA requester.
// Round-robin on contention; each access runs SETUP -> WAIT -> DONE.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   cpu_req/_address/_data_in/_write   CPU request, held until cpu_ack
//   cpu_data_out, cpu_ack              CPU read data, one-cycle ack pulse
//   dma_*                              same handshake, DMA side
//   bus_address/_data_in/_enable/_write_enable   to memory_bus
//   bus_data_out, bus_halt             from memory_bus (halt = not done)
//   grant_dma           1 while the current/last access belongs to DMA
//   timeout_error       sticky abort flag
//
// Optional feature: define ARB_TIMEOUT_EN to abort accesses that stay
// halted for TIMEOUT_CYCLES consecutive WAIT cycles.

module bus_arbiter #(
   parameter int SETTLE_CYCLES = 1
`ifdef ARB_TIMEOUT_EN
  ,parameter int TIMEOUT_CYCLES = 4096
`endif
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_req,
   input  logic [23:0] cpu_address,
   input  logic [7:0]  cpu_data_in,
   input  logic        cpu_write,
   output logic [7:0]  cpu_data_out,
   output logic        cpu_ack,
   input  logic        dma_req,
   input  logic [23:0] dma_address,
   input  logic [7:0]  dma_data_in,
   input  logic        dma_write,
   output logic [7:0]  dma_data_out,
   output logic        dma_ack,
   output logic [23:0] bus_address,
   output logic [7:0]  bus_data_in,
   input  logic [7:0]  bus_data_out,
   output logic        bus_enable,
   output logic        bus_write_enable,
   input  logic        bus_halt,
   output logic        grant_dma,
   output logic        timeout_error
);

   localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SETUP = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]    state;
   logic          last_grant;  // 1 = DMA owned the previous access
   logic [SW-1:0] settle_cnt;
   logic          any_req;
   logic          pick_dma;
   logic          abort;

   assign any_req  = cpu_req | dma_req;
   // On a tie the side that did not go last wins.
   assign pick_dma = dma_req & (~cpu_req | ~last_grant);

`ifdef ARB_TIMEOUT_EN
   logic [12:0] wait_cnt;

   assign abort = (state == S_WAIT) && bus_halt &&
                  (wait_cnt == 13'(TIMEOUT_CYCLES - 1));

   // Counts consecutive halted WAIT cycles; zero outside WAIT.
   always_ff @(posedge clk) begin
      if (reset || state != S_WAIT)
         wait_cnt <= '0;
      else if (bus_halt)
         wait_cnt <= wait_cnt + 13'd1;
   end

   always_ff @(posedge clk) begin
      if (reset)
         timeout_error <= 1'b0;
      else if (abort)
         timeout_error <= 1'b1;
   end
`else
   assign abort         = 1'b0;
   assign timeout_error = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state            <= S_IDLE;
         last_grant       <= 1'b1;
         settle_cnt       <= '0;
         grant_dma        <= 1'b0;
         bus_address      <= '0;
         bus_data_in      <= '0;
         bus_enable       <= 1'b0;
         bus_write_enable <= 1'b0;
         cpu_ack          <= 1'b0;
         dma_ack          <= 1'b0;
         cpu_data_out     <= '0;
         dma_data_out     <= '0;
      end else begin
         cpu_ack <= 1'b0;
         dma_ack <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (any_req) begin
                  grant_dma        <= pick_dma;
                  bus_address      <= pick_dma ? dma_address : cpu_address;
                  bus_data_in      <= pick_dma ? dma_data_in : cpu_data_in;
                  bus_write_enable <= pick_dma ? dma_write : cpu_write;
                  bus_enable       <= 1'b1;
                  settle_cnt       <= '0;
                  state            <= S_SETUP;
               end
            end
            S_SETUP: begin
               if (settle_cnt == SETTLE_LAST)
                  state <= S_WAIT;
               else
                  settle_cnt <= settle_cnt + SW'(1);
            end
            S_WAIT: begin
               if (!bus_halt || abort) begin
                  state            <= S_DONE;
                  bus_enable       <= 1'b0;
                  bus_write_enable <= 1'b0;
                  if (grant_dma)
                     dma_ack <= 1'b1;
                  else
                     cpu_ack <= 1'b1;
                  // Reads return bus data, or 8'hff when aborted.
                  if (!bus_write_enable) begin
                     if (grant_dma)
                        dma_data_out <= abort ? 8'hff : bus_data_out;
                     else
                        cpu_data_out <= abort ? 8'hff : bus_data_out;
                  end
               end
            end
            S_DONE: begin
               last_grant <= grant_dma;
               state      <= S_IDLE;
            end
         endcase
      end
   end

endmodule
